// File: rtl/qdr_resp_pkg.sv
// Shared definitions for the QDR-II SRAM bank responder: lane geometry,
// FSM state encoding and the legal read-latency window.
package qdr_resp_pkg;

  localparam int LANE_W = 9;
  localparam int LANE_N = 4;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } qdr_state_e;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/qdr_resp_rd_pipe.sv
// Read return pipeline: a LATENCY-deep valid/data shift register with a
// synchronous flush. Data is forced to zero whenever its valid bit is low so
// that the output never shows stale words.
module qdr_resp_rd_pipe #(
  parameter int DATA_WIDTH = 36,
  parameter int LATENCY    = 2
) (
  input  logic                  memclk,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [LATENCY-1:0]    vld_sr;
  logic [DATA_WIDTH-1:0] dat_sr [LATENCY];

  // Shift valid/data one stage per cycle; flush drops everything in flight.
  always_ff @(posedge memclk) begin
    if (flush) begin
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_sr[i] <= '0;
      end
    end else begin
      vld_sr[0] <= in_valid;
      dat_sr[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        dat_sr[i] <= dat_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[LATENCY-1];
  assign out_data  = dat_sr[LATENCY-1];

endmodule

// File: rtl/qdr_sram_responder.sv
// Memory-side responder standing in for one QDR-II SRAM bank port.
// Clears its storage with an internal sweep after reset, then services
// byte-lane writes and fixed-latency reads with a cq-style valid strobe.
// Optional build macro: QDR_SRAM_RESPONDER_STATS_EN adds saturating
// wr_count / rd_count outputs for accepted commands.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | clear sweep: zero written at ptr each cycle, commands ignored
// READY | sweep complete, reads and writes accepted until next reset
module qdr_sram_responder
  import qdr_resp_pkg::*;
#(
  parameter int DATA_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 19,
  parameter int DEPTH_BITS   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  memclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] qdr_d,
  input  logic [ADDR_WIDTH-1:0] qdr_sa,
  input  logic                  qdr_w_n,
  input  logic                  qdr_r_n,
  input  logic [LANE_N-1:0]     qdr_bw_n,
  output logic [DATA_WIDTH-1:0] qdr_q,
  output logic                  qdr_q_valid,
  output logic                  init_done
`ifdef QDR_SRAM_RESPONDER_STATS_EN
  ,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  if (DATA_WIDTH != LANE_W * LANE_N) begin : g_bad_data_width
    $error("qdr_sram_responder: DATA_WIDTH must be LANE_W*LANE_N");
  end
  if (DEPTH_BITS > ADDR_WIDTH) begin : g_bad_depth
    $error("qdr_sram_responder: DEPTH_BITS must not exceed ADDR_WIDTH");
  end
  if (!rd_lat_ok(READ_LATENCY)) begin : g_bad_latency
    $error("qdr_sram_responder: READ_LATENCY outside legal range");
  end

  qdr_state_e            state;
  qdr_state_e            state_nxt;
  logic [DEPTH_BITS-1:0] ptr;
  logic [DEPTH_BITS-1:0] ptr_nxt;
  logic                  sweep_we;
  logic                  cmd_wr;
  logic                  cmd_rd;
  logic [DEPTH_BITS-1:0] addr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_word_q;

  // Upper address bits alias onto the implemented depth.
  assign addr = qdr_sa[DEPTH_BITS-1:0];

  if (ADDR_WIDTH > DEPTH_BITS) begin : g_alias
    logic unused_sa_hi;
    assign unused_sa_hi = ^qdr_sa[ADDR_WIDTH-1:DEPTH_BITS];
  end

  // FSM state and sweep pointer registers.
  always_ff @(posedge memclk) begin
    if (reset) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state logic; commands are only qualified once the sweep is done.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sweep_we  = 1'b0;
    cmd_wr    = 1'b0;
    cmd_rd    = 1'b0;
    case (state)
      INIT: begin
        sweep_we = 1'b1;
        ptr_nxt  = ptr + 1'b1;
        if (ptr == '1) begin
          state_nxt = READY;
        end
      end
      READY: begin
        cmd_wr = ~qdr_w_n;
        cmd_rd = ~qdr_r_n;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign init_done = (state == READY);

  // Storage write port: sweep clears, otherwise per-lane masked writes.
  always_ff @(posedge memclk) begin
    if (!reset) begin
      if (sweep_we) begin
        mem[ptr] <= '0;
      end else if (cmd_wr) begin
        for (int i = 0; i < LANE_N; i++) begin
          if (!qdr_bw_n[i]) begin
            mem[addr][i*LANE_W +: LANE_W] <= qdr_d[i*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  // Synchronous read port; sampling on the same edge as a write to the same
  // word returns the old contents, giving read-before-write for free.
  always_ff @(posedge memclk) begin
    if (reset) begin
      rd_vld_q  <= 1'b0;
      rd_word_q <= '0;
    end else begin
      rd_vld_q  <= cmd_rd;
      rd_word_q <= cmd_rd ? mem[addr] : '0;
    end
  end

  // The read-port register above plus READ_LATENCY pipe stages put the
  // result on qdr_q exactly READ_LATENCY edges after the sampling edge.
  qdr_resp_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (READ_LATENCY)
  ) u_rd_pipe (
    .memclk    (memclk),
    .flush     (reset),
    .in_valid  (rd_vld_q),
    .in_data   (rd_word_q),
    .out_valid (qdr_q_valid),
    .out_data  (qdr_q)
  );

`ifdef QDR_SRAM_RESPONDER_STATS_EN
  // Saturating counters of accepted commands; masked-out writes still count.
  always_ff @(posedge memclk) begin
    if (reset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (cmd_wr && (wr_count != 32'hFFFF_FFFF)) begin
        wr_count <= wr_count + 32'd1;
      end
      if (cmd_rd && (rd_count != 32'hFFFF_FFFF)) begin
        rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule
